// File: rtl/data_memory.sv
// rtl/data_memory.sv - wait-state data memory on a shared bidirectional bus
module data_memory #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Address_bus,
  inout  wire  [7:0] Data_bus,
  input  logic       M_read,
  input  logic       M_write,
  output logic       M_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] addr_q;
  logic       op_q;      // 1 = write, 0 = read
  logic       strobe;    // the strobe that started the current access
  logic       wr_en;
  logic       drive_en;
  logic [7:0] mem [DEPTH];

  assign strobe   = op_q ? M_write : M_read;
  assign busy     = (state != IDLE);
  assign M_ready  = (state == ACCESS) && strobe;
  assign wr_en    = (state == ACCESS) && op_q && M_write;
  // Never drive while the MDR may be driving (M_write high)
  assign drive_en = (state == ACCESS) && !op_q && M_read && !M_write;
  assign Data_bus = drive_en ? mem[addr_q] : 8'bz;

  // Access sequencer: accept in IDLE, count wait states, one ACCESS cycle, abort on strobe drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 8'd0;
      op_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (M_write || M_read) begin
            addr_q <= Address_bus;
            op_q   <= M_write;
            cnt    <= WS;
            state  <= (WS == 4'd0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (!strobe) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ACCESS;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; a write lands on the edge that ends ACCESS
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= Data_bus;
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed vector bench for data_memory
module tb_data_memory;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] addr0 = 8'd0, addr1 = 8'd0;
  logic       rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic       oe0 = 1'b0, oe1 = 1'b0;
  logic [7:0] md0 = 8'd0, md1 = 8'd0;
  logic       rdy0, rdy1, busy0, busy1;
  wire  [7:0] bus0, bus1;

  assign bus0 = oe0 ? md0 : 8'bz;
  assign bus1 = oe1 ? md1 : 8'bz;

  always #5 clk = ~clk;

  data_memory #(.WAIT_STATES(0), .DEPTH(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .Address_bus(addr0), .Data_bus(bus0),
    .M_read(rd0), .M_write(wr0), .M_ready(rdy0), .busy(busy0)
  );

  data_memory #(.WAIT_STATES(2), .DEPTH(256)) dut1 (
    .clk(clk), .rst_n(rst_n), .Address_bus(addr1), .Data_bus(bus1),
    .M_read(rd1), .M_write(wr1), .M_ready(rdy1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic r, input logic w, input logic [7:0] a,
                       input logic oe, input logic [7:0] d);
    if (u == 0) begin
      rd0 = r; wr0 = w; addr0 = a; oe0 = oe; md0 = d;
    end else begin
      rd1 = r; wr1 = w; addr1 = a; oe1 = oe; md1 = d;
    end
  endtask

  function automatic logic get_ready(input int u);
    return (u == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [7:0] get_bus(input int u);
    return (u == 0) ? bus0 : bus1;
  endfunction

  function automatic logic get_oe(input int u);
    return (u == 0) ? dut0.drive_en : dut1.drive_en;
  endfunction

  // Full protocol access: strobe until M_ready, drop strobe in the following cycle
  task automatic access(input int u, input bit w, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output int lat, output int bcnt);
    @(negedge clk);
    drive(u, !w, w, a, w, d);
    lat = 0; bcnt = 0; rdata = 8'd0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (get_busy(u)) bcnt++;
      if (get_ready(u)) begin
        lat = n;
        rdata = get_bus(u);
        break;
      end
    end
    @(negedge clk);
    drive(u, 1'b0, 1'b0, a, 1'b0, 8'd0);
  endtask

  typedef struct {
    int         u;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] rdata;
    int lat, bcnt;
    logic seen;

    vecs[0] = '{1, 1'b1, 8'h10, 8'hA5, 3};
    vecs[1] = '{1, 1'b0, 8'h10, 8'hA5, 3};
    vecs[2] = '{1, 1'b1, 8'h21, 8'h00, 3};
    vecs[3] = '{1, 1'b1, 8'h30, 8'h99, 3};
    vecs[4] = '{0, 1'b1, 8'h00, 8'h11, 1};
    vecs[5] = '{0, 1'b1, 8'hFF, 8'h3C, 1};
    vecs[6] = '{0, 1'b0, 8'hFF, 8'h3C, 1};
    vecs[7] = '{0, 1'b0, 8'h00, 8'h11, 1};
    vecs[8] = '{1, 1'b0, 8'h30, 8'h99, 3};

    #12;
    check("reset_busy0", 32'(busy0), 32'd0);
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_ready1", 32'(rdy1), 32'd0);
    check("reset_oe1", 32'(dut1.drive_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      access(vecs[i].u, vecs[i].w, vecs[i].a, vecs[i].d, rdata, lat, bcnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
      check($sformatf("v%0d_idle_after", i), 32'(get_busy(vecs[i].u)), 32'd0);
      if (!vecs[i].w) check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].d));
    end

    // Abort a read during WAIT
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 8'h20, 1'b0, 8'd0);
    @(negedge clk);
    check("abort_rd_busy_wait", 32'(busy1), 32'd1);
    check("abort_rd_ready_wait", 32'(rdy1), 32'd0);
    drive(1, 1'b0, 1'b0, 8'h20, 1'b0, 8'd0);
    @(negedge clk);
    check("abort_rd_idle", 32'(busy1), 32'd0);
    check("abort_rd_ready", 32'(rdy1), 32'd0);
    check("abort_rd_bus_released", 32'(dut1.drive_en), 32'd0);

    // Abort a write during WAIT; memory must keep its old value
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 8'h21, 1'b1, 8'h77);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 8'h21, 1'b0, 8'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rdy1;
    end
    check("abort_wr_no_ready", 32'(seen), 32'd0);
    access(1, 1'b0, 8'h21, 8'd0, rdata, lat, bcnt);
    check("abort_wr_rdata", 32'(rdata), 32'h00);

    // Reset in the middle of a write
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 8'h30, 1'b1, 8'h55);
    @(negedge clk);
    check("rst_mid_busy_before", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy_now", 32'(busy1), 32'd0);
    check("rst_mid_ready_now", 32'(rdy1), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 8'h30, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 8'h30, 8'd0, rdata, lat, bcnt);
    check("rst_mid_lat", 32'(lat), 32'd3);
    check("rst_mid_rdata", 32'(rdata), 32'h99);

    // Both strobes high: treated as a write, bus never driven by the memory
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'h05, 1'b1, 8'h42);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check($sformatf("both_no_drive_c%0d", n), 32'(get_oe(1)), 32'd0);
      if (rdy1) begin
        lat = n;
        break;
      end
    end
    check("both_latency", 32'(lat), 32'd3);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 8'h05, 1'b0, 8'd0);
    access(1, 1'b0, 8'h05, 8'd0, rdata, lat, bcnt);
    check("both_rdata", 32'(rdata), 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
